// File: rtl/roll_uart_tx_pkg.sv
// Shared definitions for the die-roll UART transmitter: state encodings, ASCII
// constants and the decimal split / message byte helpers.
package roll_uart_tx_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_START = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd4;
  localparam logic [STATE_W-1:0] ST_NEXT  = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;

  // Face values never exceed 32, so the tens digit fits in two bits.
  function automatic logic [1:0] bcd_tens(input logic [5:0] value);
    return 2'(value / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] value);
    return 4'(value % 6'd10);
  endfunction

  // A one-digit value skips the tens slot, so its byte index is shifted by one.
  function automatic logic [7:0] msg_byte(input logic [1:0] tens,
                                          input logic [3:0] ones,
                                          input logic [1:0] idx);
    logic [1:0] pos;
    pos = (tens == 2'd0) ? idx + 2'd1 : idx;
    case (pos)
      2'd0:    return ASC_ZERO + {6'd0, tens};
      2'd1:    return ASC_ZERO + {4'd0, ones};
      2'd2:    return ASC_CR;
      default: return ASC_LF;
    endcase
  endfunction

endpackage

// File: rtl/roll_uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, one stop bit.
// Accepts a byte only while idle; o_tx is registered and idles high.
module uart_tx_byte
  import roll_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  logic [STATE_W-1:0] state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift_q;
  logic               bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign o_ready = (state == ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; a later assignment in the same branch overrides an earlier one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      o_tx     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          o_tx     <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (i_valid) begin
            shift_q <= i_data;
            o_tx    <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            o_tx     <= shift_q[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              o_tx  <= 1'b1;
              state <= ST_STOP;
            end else begin
              o_tx    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          o_tx     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/roll_uart_tx.sv
// Sends a finished die roll as ASCII decimal face value plus CR LF over UART.
// Captures the roll, splits it into digits and sequences bytes into the serializer.
module roll_uart_tx
  import roll_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [4:0] i_dieRoll,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

  logic [STATE_W-1:0] state;
  logic [5:0]         value_q;
  logic [1:0]         tens_q;
  logic [3:0]         ones_q;
  logic [1:0]         idx;
  logic [1:0]         last_idx;
  logic [1:0]         send_idx;
  logic               ser_valid;
  logic               ser_ready;
  logic [7:0]         ser_data;

  assign last_idx = (tens_q == 2'd0) ? 2'd2 : 2'd3;
  assign o_busy   = (state != ST_IDLE);
  assign o_done   = (state == ST_DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ser_valid = 1'b0;
    send_idx  = idx;
    if (state == ST_START) begin
      ser_valid = 1'b1;
    end else if (state == ST_NEXT && ser_ready && idx != last_idx) begin
      // The single idle cycle between bytes doubles as the hand-off of the next byte.
      ser_valid = 1'b1;
      send_idx  = idx + 2'd1;
    end
  end

  assign ser_data = msg_byte(tens_q, ones_q, send_idx);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      value_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            value_q <= {1'b0, i_dieRoll} + 6'd1;
            idx     <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tens_q <= bcd_tens(value_q);
          ones_q <= bcd_ones(value_q);
          state  <= ST_START;
        end
        ST_START: begin
          state <= ST_NEXT;
        end
        // NEXT waits out the byte in flight; the cycle the serializer is idle again
        // either launches the following byte or finishes the message.
        ST_NEXT: begin
          if (ser_ready) begin
            if (idx == last_idx) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_valid  (ser_valid),
    .i_data   (ser_data),
    .o_ready  (ser_ready),
    .o_tx     (o_tx)
  );

endmodule
